// File: rtl/sram_arb_pkg.sv
// Shared definitions for the external SRAM arbiter/controller.
//   state_t        : transaction sequencer states (IDLE -> LO -> HI -> DONE)
//   REQ_IF/REQ_LS  : requester IDs used for the winner latch and RR pointer
//   sram_ctl_t     : bundle of the five active-low SRAM control pins
//   SRAM_CTL_IDLE  : all controls deasserted
//   phase_ctl()    : control pin values for one active halfword phase
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef struct packed {
        logic ce_n;
        logic we_n;
        logic oe_n;
        logic lb_n;
        logic ub_n;
    } sram_ctl_t;

    localparam sram_ctl_t SRAM_CTL_IDLE = 5'b11111;

    // Reads enable both byte lanes; writes enable only the lanes whose
    // byte-mask bits are set, so a zero mask runs a harmless phase.
    function automatic sram_ctl_t phase_ctl(input logic wren, input logic [1:0] lanes);
        sram_ctl_t c;
        c.ce_n = 1'b0;
        if (wren) begin
            c.we_n = 1'b0;
            c.oe_n = 1'b1;
            c.lb_n = ~lanes[0];
            c.ub_n = ~lanes[1];
        end else begin
            c.we_n = 1'b1;
            c.oe_n = 1'b0;
            c.lb_n = 1'b0;
            c.ub_n = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/sram_pad_if.sv
// SRAM pin interface: registers every SRAM pin output, owns the dq
// tri-state enable and the 32-bit read-capture register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ph_act          : next cycle is an active halfword phase
//   ph_hi           : next phase is the upper halfword (address LSB)
//   ph_wren         : next phase is a write
//   ph_addr         : word address (SRAM address without its LSB)
//   ph_lanes        : byte-lane enables for the next write phase
//   ph_wdata        : halfword to drive during the next write phase
//   cap_lo, cap_hi  : sample dq into rd_data[15:0] / rd_data[31:16]
//   sram_addr, sram_*_n : registered SRAM address and controls
//   rd_data         : assembled read word
//   sram_dq         : bidirectional SRAM data bus
module sram_pad_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ph_act,
    input  logic              ph_hi,
    input  logic              ph_wren,
    input  logic [ADDR_W-2:0] ph_addr,
    input  logic [1:0]        ph_lanes,
    input  logic [15:0]       ph_wdata,
    input  logic              cap_lo,
    input  logic              cap_hi,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [31:0]       rd_data,
    inout  wire  [15:0]       sram_dq
);

    sram_ctl_t   ctl_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= '0;
            ctl_q     <= SRAM_CTL_IDLE;
            dq_oe_q   <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (ph_act) begin
                sram_addr <= {ph_addr, ph_hi};
                ctl_q     <= phase_ctl(ph_wren, ph_lanes);
                // dq is only ever driven together with we_n low and oe_n high
                dq_oe_q   <= ph_wren;
            end else begin
                ctl_q     <= SRAM_CTL_IDLE;
                dq_oe_q   <= 1'b0;
            end
            if (cap_lo) rd_data[15:0]  <= sram_dq;
            if (cap_hi) rd_data[31:16] <= sram_dq;
        end
    end

    always_ff @(posedge clk) begin
        if (ph_act) dq_out_q <= ph_wdata;
    end

    assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign sram_ce_n = ctl_q.ce_n;
    assign sram_we_n = ctl_q.we_n;
    assign sram_oe_n = ctl_q.oe_n;
    assign sram_lb_n = ctl_q.lb_n;
    assign sram_ub_n = ctl_q.ub_n;

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbiter/sequencer for the board's 16-bit asynchronous SRAM, shared by the
// instruction-fetch port (read-only) and the load/store unit. Each 32-bit
// access runs as a low then a high halfword phase of WAIT_CYC cycles each,
// followed by a one-cycle DONE where the winner's ack pulses.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_if_req/i_if_addr        : fetch request and byte address
//   o_if_rdata/o_if_ack       : fetch data and completion pulse
//   i_ls_req/wren/addr/bmask/wdata : LSU request fields
//   o_ls_rdata/o_ls_ack       : LSU read data and completion pulse
//   o_busy                    : a transaction is in progress
//   o_sram_* / io_sram_dq     : registered SRAM pins and data bus
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_ls_req,
    input  logic              i_ls_wren,
    input  logic [31:0]       i_ls_addr,
    input  logic [3:0]        i_ls_bmask,
    input  logic [31:0]       i_ls_wdata,
    output logic [31:0]       o_ls_rdata,
    output logic              o_ls_ack,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ptr_q;
    logic              win_q;
    logic              wren_q;
    logic              busy_q;
    logic              if_ack_q;
    logic              ls_ack_q;
    logic [ADDR_W-2:0] addr_q;
    logic [3:0]        bmask_q;
    logic [31:0]       wdata_q;

    logic              launch;
    logic              win_nxt;
    logic              sel_wren;
    logic [ADDR_W-2:0] sel_addr;
    logic [3:0]        sel_bmask;
    logic [31:0]       sel_wdata;
    logic              phase_last;
    logic              ph_act;
    logic              ph_hi;
    logic              cur_wren;
    logic [ADDR_W-2:0] cur_addr;
    logic [3:0]        cur_bmask;
    logic [31:0]       cur_wdata;
    logic [31:0]       rd_data;
    logic              unused_addr_bits;

    // Byte-offset bits and bits beyond the SRAM size are dropped on purpose.
    assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+1], i_if_addr[1:0],
                                i_ls_addr[31:ADDR_W+1], i_ls_addr[1:0]};

    // Arbitration: a contested IDLE cycle goes to the RR pointer; an
    // uncontested one goes to whoever asks. Either way the pointer then
    // names the loser of this round.
    always_comb begin
        launch  = (state_q == IDLE) && (i_if_req || i_ls_req);
        if (i_if_req && i_ls_req) win_nxt = ptr_q;
        else if (i_ls_req)        win_nxt = REQ_LS;
        else                      win_nxt = REQ_IF;

        if (win_nxt == REQ_LS) begin
            sel_wren  = i_ls_wren;
            sel_addr  = i_ls_addr[ADDR_W:2];
            sel_bmask = i_ls_bmask;
            sel_wdata = i_ls_wdata;
        end else begin
            sel_wren  = 1'b0;
            sel_addr  = i_if_addr[ADDR_W:2];
            sel_bmask = 4'b1111;
            sel_wdata = '0;
        end
    end

    // Pin values are registered, so the pad is fed the values for the
    // *next* cycle; on launch these come straight from the request.
    always_comb begin
        phase_last = (cnt_q == CNT_LAST);
        ph_act     = launch || (state_q == LO) || ((state_q == HI) && !phase_last);
        ph_hi      = ((state_q == LO) && phase_last) || (state_q == HI);
        cur_wren   = launch ? sel_wren  : wren_q;
        cur_addr   = launch ? sel_addr  : addr_q;
        cur_bmask  = launch ? sel_bmask : bmask_q;
        cur_wdata  = launch ? sel_wdata : wdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= REQ_LS;
            win_q    <= REQ_IF;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= LO;
                        cnt_q   <= '0;
                        win_q   <= win_nxt;
                        ptr_q   <= ~win_nxt;
                        wren_q  <= sel_wren;
                        busy_q  <= 1'b1;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        state_q <= HI;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                HI: begin
                    if (phase_last) begin
                        state_q  <= DONE;
                        cnt_q    <= '0;
                        if_ack_q <= (win_q == REQ_IF);
                        ls_ack_q <= (win_q == REQ_LS);
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request fields are data only; they are meaningful once launched.
    always_ff @(posedge i_clk) begin
        if (launch) begin
            addr_q  <= sel_addr;
            bmask_q <= sel_bmask;
            wdata_q <= sel_wdata;
        end
    end

    // -------- pad stage: registered SRAM pins and read capture --------
    sram_pad_if #(.ADDR_W(ADDR_W)) u_pad (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .ph_act    (ph_act),
        .ph_hi     (ph_hi),
        .ph_wren   (cur_wren),
        .ph_addr   (cur_addr),
        .ph_lanes  (ph_hi ? cur_bmask[3:2] : cur_bmask[1:0]),
        .ph_wdata  (ph_hi ? cur_wdata[31:16] : cur_wdata[15:0]),
        .cap_lo    ((state_q == LO) && phase_last && !wren_q),
        .cap_hi    ((state_q == HI) && phase_last && !wren_q),
        .sram_addr (o_sram_addr),
        .sram_ce_n (o_sram_ce_n),
        .sram_we_n (o_sram_we_n),
        .sram_oe_n (o_sram_oe_n),
        .sram_lb_n (o_sram_lb_n),
        .sram_ub_n (o_sram_ub_n),
        .rd_data   (rd_data),
        .sram_dq   (io_sram_dq)
    );

    // The capture register only changes on reads, so write acks leave the
    // returned data as it was.
    assign o_if_rdata = rd_data;
    assign o_ls_rdata = rd_data;
    assign o_if_ack   = if_ack_q;
    assign o_ls_ack   = ls_ack_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Arbitrates the board's external 16-bit asynchronous SRAM between the pipeline's instruction-fetch port (read-only) and the load/store unit, and sequences each 32-bit access as two halfword SRAM phases. Sits between the core's memory interfaces and the FPGA SRAM pins (SRAM_ADDR/DQ/CE_N/WE_N/OE_N/LB_N/UB_N). All SRAM pin outputs are registered.

Parameters:
ADDR_W, 18, SRAM halfword address width
WAIT_CYC, 1, clock cycles per halfword phase (>=1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_if_req  in  1  fetch request; held with i_if_addr until o_if_ack
i_if_addr  in  32  fetch byte address
o_if_rdata  out  32  fetch read data, valid with o_if_ack
o_if_ack  out  1  one-cycle fetch completion pulse
i_ls_req  in  1  LSU request; fields held until o_ls_ack
i_ls_wren  in  1  1=write, 0=read
i_ls_addr  in  32  LSU byte address
i_ls_bmask  in  4  byte-lane enables for writes
i_ls_wdata  in  32  write data
o_ls_rdata  out  32  LSU read data, valid with o_ls_ack
o_ls_ack  out  1  one-cycle LSU completion pulse
o_busy  out  1  high whenever FSM is not IDLE
o_sram_addr  out  ADDR_W  SRAM halfword address
io_sram_dq  inout  16  SRAM data bus
o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM active-low controls

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; acks 0; rdata 0; o_sram_addr 0; ce_n/we_n/oe_n/lb_n/ub_n all 1; dq high-Z; RR pointer = LSU-first. Takes effect immediately, including mid-transaction; the in-flight transaction is discarded without ack.
- FSM: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE: sample requests. Only one pending -> grant it. Both pending -> grant the requester named by the RR pointer, then point the pointer at the other. A single uncontested grant also moves the pointer to the other requester. Latch addr/wren/bmask/wdata and the winner ID.
- LO: WAIT_CYC cycles; o_sram_addr = {addr[ADDR_W:2], 1'b0}; ce_n=0.
  - Read: oe_n=0, lb_n=ub_n=0, dq high-Z; capture dq into rdata[15:0] on the last cycle of the phase.
  - Write: we_n=0, oe_n=1, dq driven with wdata[15:0], lb_n=~bmask[0], ub_n=~bmask[1].
- HI: same as LO with address LSB=1, data bits [31:16], and bmask[3:2].
- DONE: SRAM controls return to idle values; dq high-Z; pulse the winner's ack for 1 cycle with rdata valid. Write acks leave rdata unchanged. Then go to IDLE.
- Latency, request sampled in IDLE at cycle t: ack at t+2*WAIT_CYC+1. Throughput: one access per 2*WAIT_CYC+2 cycles.
- Requester sees ack and drops or changes req on that same edge. The IDLE cycle after DONE therefore sees the updated req. A held req starts a new transaction.
- Fetch is always treated as a read; i_ls_wren is ignored for fetch.
- Write with bmask=0: both phases still run with lb_n=ub_n=1 (no memory change); ack still issued.
- Address bits [1:0] are ignored (word aligned). Bits above ADDR_W+1 are ignored (wraps modulo SRAM size).
- A req dropped before ack is a protocol violation. The controller completes the latched transaction and still pulses ack.
- dq is never driven while oe_n=0. Every phase boundary passes through DONE/IDLE or keeps the same direction, so there is no bus contention.

Decomposition:
- Shared package sram_arb_pkg: state enum (IDLE, LO, HI, DONE), requester ID constants (REQ_IF=0, REQ_LS=1), SRAM idle control constant.
- One sub-module, sram_pad_if: registered SRAM control/address flops, dq tri-state output enable, and read-capture register.

Test Plan:
1. Assert reset, then release -> ce_n/we_n/oe_n/lb_n/ub_n=1, dq=Z, acks=0, o_busy=0.
2. Fetch read at 0x0000_0010; model hw[8]=0x5678, hw[9]=0x1234 (WAIT_CYC=1) -> addr 8 then 9 with oe_n=0; o_if_ack at t+3; o_if_rdata=0x12345678.
3. LSU write 0xDEADBEEF to 0x20, bmask 4'b1111 -> we_n low both phases; hw16=0xBEEF, hw17=0xDEAD; o_ls_ack at t+3; dq Z after DONE.
4. LSU write 0x00AB0000 to 0x20, bmask 4'b0100 -> LO phase lb_n=ub_n=1; HI phase lb_n=0, ub_n=1; read-back via fetch returns 0xDEABBEEF.
5. Both reqs raised together after reset and held for 4 transactions -> grant order LS, IF, LS, IF; each ack exactly 1 cycle.
6. Reset asserted during HI phase of an LSU read -> all controls idle asynchronously, no o_ls_ack. After release, a new fetch completes normally with correct data.
